issue_scoreboard: RTL

- Sits between instruction fetch and the register-file read stage. Gates each decoded instruction's register addresses (a, b, m, d) into a one-entry issue register.
- Stalls on RAW and WAW hazards using a per-register busy scoreboard. Busy bits clear on writeback.
- Enforces register privilege: an unprivileged access to a privileged register is dropped and raises a sticky fault.
- Provides a flush/drain sequence for trap and mode switches.

---
 rtl/issue_scoreboard.sv | 99 +++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: gates decoded instructions into a one-entry issue register,
// stalling on RAW/WAW hazards, dropping privilege violations and draining on flush.
module issue_scoreboard #(
   parameter int NREG = 16,
   parameter logic [NREG-1:0] PRIV_MASK = 16'hF000,
   parameter int STALL_W = 16,
   localparam int AW = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [AW-1:0]      in_ra_a,
   input  logic [AW-1:0]      in_ra_b,
   input  logic [AW-1:0]      in_ra_m,
   input  logic [AW-1:0]      in_ra_d,
   input  logic [3:0]         in_use,
   input  logic               in_priv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [AW-1:0]      out_ra_a,
   output logic [AW-1:0]      out_ra_b,
   output logic [AW-1:0]      out_ra_m,
   output logic [AW-1:0]      out_ra_d,
   output logic [3:0]         out_use,
   input  logic               wb_valid,
   input  logic [AW-1:0]      wb_addr,
   input  logic               flush_req,
   output logic               flush_done,
   output logic               fault,
   output logic [AW-1:0]      fault_addr,
   input  logic               fault_ack,
   output logic [STALL_W-1:0] stall_count
);
   typedef enum logic [1:0] {RUN, FAULT, FLUSH} state_t;
   state_t state;
   logic [NREG-1:0] busy, busy_eff, wb_mask, set_mask;
   logic [3:0] hit, priv_hit;
   logic slot_free, hazard, viol, issue;
   logic [AW-1:0] viol_addr;
   // writeback clears before the hazard check so a completing producer never stalls its consumer
   assign wb_mask = wb_valid ? NREG'(1) << wb_addr : '0;
   assign busy_eff = busy & ~wb_mask;
   assign slot_free = !out_valid | out_ready;
   assign hit = in_use & {busy_eff[in_ra_d], busy_eff[in_ra_m], busy_eff[in_ra_a], busy_eff[in_ra_b]};
   assign priv_hit = in_use & {PRIV_MASK[in_ra_d], PRIV_MASK[in_ra_m], PRIV_MASK[in_ra_a], PRIV_MASK[in_ra_b]} & {4{!in_priv}};
   assign hazard = |hit;
   assign viol = |priv_hit;
   assign in_ready = state == RUN & in_valid & !flush_req & (viol | slot_free & !hazard);
   assign issue = in_ready & !viol;
   assign set_mask = issue & in_use[3] ? NREG'(1) << in_ra_d : '0;
   assign viol_addr = priv_hit[3] ? in_ra_d : priv_hit[2] ? in_ra_m : priv_hit[1] ? in_ra_a : in_ra_b;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         busy        <= '0;
         out_valid   <= 1'b0;
         out_ra_a    <= '0;
         out_ra_b    <= '0;
         out_ra_m    <= '0;
         out_ra_d    <= '0;
         out_use     <= '0;
         fault       <= 1'b0;
         fault_addr  <= '0;
         flush_done  <= 1'b0;
         stall_count <= '0;
      end else begin
         busy       <= busy_eff | set_mask;
         out_valid  <= issue | out_valid & !out_ready;
         flush_done <= state == FLUSH & !out_valid & busy == '0;
         if (issue) begin
            out_ra_a <= in_ra_a;
            out_ra_b <= in_ra_b;
            out_ra_m <= in_ra_m;
            out_ra_d <= in_ra_d;
            out_use  <= in_use;
         end
         if (state == RUN & in_valid & !in_ready & !flush_req & !(&stall_count))
            stall_count <= stall_count + STALL_W'(1);
         case (state)
            RUN:
               if (flush_req) state <= FLUSH;
               else if (in_ready & viol) begin
                  state      <= FAULT;
                  fault      <= 1'b1;
                  fault_addr <= viol_addr;
               end
            FAULT:
               if (fault_ack) begin
                  fault <= 1'b0;
                  state <= flush_req ? FLUSH : RUN;
               end
            FLUSH:
               if (!out_valid & busy == '0) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end
endmodule
